// File: rtl/rv32imf_pkg.sv
// Shared types and helpers for the rv32imf instruction-fetch path.
package rv32imf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BR_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] WORD_STEP = 32'd4;

    // Forces a byte address onto a word boundary while still consuming every bit.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv32imf_prefetch_ctrl.sv
// Sequential instruction-fetch request engine feeding the prefetch FIFO.
// Requests are admitted only when a FIFO slot is guaranteed; branches flush and drop stale responses.
module rv32imf_prefetch_ctrl
    import rv32imf_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0080,
    parameter int unsigned CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_en_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    output logic             instr_req_o,
    output logic [31:0]      instr_addr_o,
    input  logic             instr_gnt_i,
    input  logic             instr_rvalid_i,
    input  logic [31:0]      instr_rdata_i,
    output logic             fifo_push_o,
    output logic [31:0]      fifo_data_o,
    output logic             fifo_flush_o,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    output logic             busy_o
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   br_addr_q, br_addr_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;

    logic          gnt_now;
    logic          rvalid_now;
    logic          discard_dec;
    logic          can_issue;
    logic [31:0]   out_post;
    logic [31:0]   credit_used;
    logic [31:0]   target;

    assign instr_req_o  = (state_q != IDLE);
    assign instr_addr_o = addr_q;
    assign fifo_data_o  = instr_rdata_i;
    assign fifo_flush_o = branch_i;
    assign busy_o       = instr_req_o || (outstanding_q != '0);

    always_comb begin
        gnt_now     = instr_req_o && instr_gnt_i;
        rvalid_now  = instr_rvalid_i && (outstanding_q != '0);
        discard_dec = rvalid_now && (discard_q != '0);
        target      = word_align(branch_addr_i);

        // A grant this cycle already owns a FIFO slot, so credit is judged on post-grant counts.
        out_post    = 32'(outstanding_q) + 32'(gnt_now);
        credit_used = 32'(fifo_cnt_i) + out_post;
        can_issue   = fetch_en_i && (out_post < MAX_OUTSTANDING) && (credit_used < FIFO_DEPTH);

        fifo_push_o   = rvalid_now && (discard_q == '0) && !branch_i;
        outstanding_d = outstanding_q + OW'(gnt_now) - OW'(rvalid_now);

        discard_d = discard_q - OW'(discard_dec);
        if (branch_i) begin
            // Every response still owed after this cycle belongs to the abandoned stream.
            discard_d = outstanding_d;
        end else if ((state_q == BR_WAIT) && gnt_now) begin
            discard_d = discard_q - OW'(discard_dec) + OW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        br_addr_d = br_addr_q;
        if (gnt_now) begin
            addr_d = addr_q + WORD_STEP;
        end

        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (gnt_now) begin
                    state_d = can_issue ? REQ : IDLE;
                end
            end
            BR_WAIT: begin
                if (gnt_now) begin
                    state_d = IDLE;
                    addr_d  = br_addr_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // An ungranted request must stay on the bus, so the target is parked until it is accepted.
        if (branch_i) begin
            if ((state_q == IDLE) || gnt_now) begin
                addr_d  = target;
                state_d = IDLE;
            end else begin
                br_addr_d = target;
                state_d   = BR_WAIT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= RESET_ADDR;
            br_addr_q     <= RESET_ADDR;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            br_addr_q     <= br_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (discard_q <= outstanding_q);
        end
    end

endmodule

// File: tb/tb_rv32imf_prefetch_ctrl.sv
// Scoreboard bench for rv32imf_prefetch_ctrl with a bus responder and a FIFO occupancy model.
module tb_rv32imf_prefetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        branch;
    logic [31:0] branch_addr;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        push;
    logic [31:0] pdata;
    logic        flush;
    logic [1:0]  cnt;
    logic        busy;

    always #5 clk = ~clk;

    rv32imf_prefetch_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_en_i     (fetch_en),
        .branch_i       (branch),
        .branch_addr_i  (branch_addr),
        .instr_req_o    (req),
        .instr_addr_o   (addr),
        .instr_gnt_i    (gnt),
        .instr_rvalid_i (rvalid),
        .instr_rdata_i  (rdata),
        .fifo_push_o    (push),
        .fifo_data_o    (pdata),
        .fifo_flush_o   (flush),
        .fifo_cnt_i     (cnt),
        .busy_o         (busy)
    );

    int tests  = 0;
    int failed = 0;
    int gnt_mode = 0;   // 0 always grant, 1 never grant, 2 random
    int rsp_mode = 0;   // 0 respond next cycle, 1 hold, 2 random
    int pop_req  = 0;
    logic        stream_mode = 1'b0;
    logic [31:0] stream_addr = 32'h0;
    int          stream_pushes = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] fifo_m[$];

    logic        ev_gnt = 1'b0, ev_rsp = 1'b0, ev_push = 1'b0, ev_flush = 1'b0;
    logic [31:0] ev_addr = 32'h0, ev_data = 32'h0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic check1(input string nm, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bus responder: grants per mode, returns in-order data at least one cycle after grant.
    always @(negedge clk) begin
        #1;
        case (gnt_mode)
            0:       gnt = 1'b1;
            1:       gnt = 1'b0;
            default: gnt = ($urandom_range(0, 2) != 0);
        endcase
        if (pend_q.size() != 0 && (rsp_mode == 0 || (rsp_mode == 2 && $urandom_range(0, 1) == 1))) begin
            rvalid = 1'b1;
            rdata  = mem(pend_q[0]);
        end else begin
            rvalid = 1'b0;
            rdata  = 32'hDEAD_BEEF;
        end
    end

    // Monitor: pops expectations whenever the DUT grants or pushes.
    always @(negedge clk) begin
        #2;
        ev_gnt   = req && gnt;
        ev_addr  = addr;
        ev_rsp   = rvalid;
        ev_push  = push;
        ev_data  = pdata;
        ev_flush = flush;
        if (!rst) begin
            if (!stream_mode) begin
                if (ev_gnt) begin
                    if (exp_addr_q.size() == 0) begin
                        tests++; failed++;
                        $display("FAIL grant addr: got unexpected grant at %h, expected none", addr);
                    end else begin
                        check32("grant addr", addr, exp_addr_q.pop_front());
                    end
                end
                if (push) begin
                    if (exp_data_q.size() == 0) begin
                        tests++; failed++;
                        $display("FAIL push data: got unexpected push %h, expected none", pdata);
                    end else begin
                        check32("push data", pdata, exp_data_q.pop_front());
                    end
                end
            end else begin
                if (push) begin
                    stream_pushes++;
                    if (branch) begin
                        tests++; failed++;
                        $display("FAIL branch push: got push %h in branch cycle, expected no push", pdata);
                    end else begin
                        check32("stream data", pdata, mem(stream_addr));
                        stream_addr = stream_addr + 32'd4;
                    end
                end
                if (branch) stream_addr = branch_addr & 32'hFFFF_FFFC;
            end
        end
    end

    // Apply recorded events to the outstanding-transaction list and the FIFO occupancy model.
    always @(posedge clk) begin
        logic [31:0] tmp;
        #1;
        if (rst) begin
            pend_q.delete();
            fifo_m.delete();
        end else begin
            if (ev_gnt) pend_q.push_back(ev_addr);
            if (ev_rsp && pend_q.size() != 0) tmp = pend_q.pop_front();
            if (ev_flush) begin
                fifo_m.delete();
            end else begin
                if (ev_push) begin
                    tests++;
                    if (fifo_m.size() >= DEPTH) begin
                        failed++;
                        $display("FAIL fifo overflow: got push at occupancy %0d, expected below %0d", fifo_m.size(), DEPTH);
                    end
                    fifo_m.push_back(ev_data);
                end
                for (int i = 0; i < pop_req; i++) begin
                    if (fifo_m.size() != 0) tmp = fifo_m.pop_front();
                end
            end
        end
        pop_req = 0;
        cnt = 2'(fifo_m.size());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst = 1'b1; fetch_en = 1'b0; branch = 1'b0; branch_addr = 32'h0; cnt = 2'd0;
        tick(3);
        #3;
        check1("reset req", req, 1'b0);
        check32("reset addr", addr, 32'h0000_0080);
        check1("reset push", push, 1'b0);
        check1("reset flush", flush, 1'b0);
        check1("reset busy", busy, 1'b0);

        // Fill the FIFO: two fetches, then credit stalls the engine.
        exp_addr_q = '{32'h80, 32'h84};
        exp_data_q = '{32'h5A5A_0080, 32'h5A5A_0084};
        tick(1); rst = 1'b0; fetch_en = 1'b1;
        tick(8); #3;
        check1("stall req", req, 1'b0);
        check32("stall cnt", 32'(cnt), 32'd2);
        check32("s1 addr left", 32'(exp_addr_q.size()), 32'd0);
        check32("s1 data left", 32'(exp_data_q.size()), 32'd0);
        check1("s1 busy", busy, 1'b0);

        exp_addr_q = '{32'h88, 32'h8C};
        exp_data_q = '{32'h5A5A_0088, 32'h5A5A_008C};
        tick(1); pop_req = 2;
        tick(8); #3;
        check32("s1b addr left", 32'(exp_addr_q.size()), 32'd0);
        check32("s1b data left", 32'(exp_data_q.size()), 32'd0);

        // Grant withheld while fetch_en toggles, then a branch parks its target.
        exp_addr_q = '{32'h90, 32'h2000, 32'h2004};
        exp_data_q = '{32'h5A5A_2000, 32'h5A5A_2004};
        tick(1); gnt_mode = 1; pop_req = 2;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (req) found = 1'b1;
        end
        check1("s2 req appears", found, 1'b1);
        for (int i = 0; i < 5; i++) begin
            fetch_en = ~fetch_en;
            #3;
            check1("held req", req, 1'b1);
            check32("held addr", addr, 32'h90);
            tick(1);
        end
        fetch_en = 1'b1; branch = 1'b1; branch_addr = 32'h2000;
        #3;
        check1("s4 flush", flush, 1'b1);
        tick(1); branch = 1'b0;
        #3;
        check1("s4 flush off", flush, 1'b0);
        check1("s4 held req", req, 1'b1);
        check32("s4 held addr", addr, 32'h90);
        tick(1); gnt_mode = 0;
        tick(8); #3;
        check32("s4 addr left", 32'(exp_addr_q.size()), 32'd0);
        check32("s4 data left", 32'(exp_data_q.size()), 32'd0);

        // Two outstanding, then branch to an unaligned target.
        exp_addr_q = '{32'h2008, 32'h200C, 32'h1000, 32'h1004};
        exp_data_q = '{32'h5A5A_1000, 32'h5A5A_1004};
        tick(1); rsp_mode = 1; pop_req = 2;
        tick(6); #3;
        check1("s3 idle req", req, 1'b0);
        check1("s3 busy", busy, 1'b1);
        tick(1); branch = 1'b1; branch_addr = 32'h1003;
        #3;
        check1("s3 flush", flush, 1'b1);
        tick(1); branch = 1'b0; rsp_mode = 0;
        #3;
        check32("s3 discard", 32'(dut.discard_q), 32'd2);
        tick(10); #3;
        check32("s3 addr left", 32'(exp_addr_q.size()), 32'd0);
        check32("s3 data left", 32'(exp_data_q.size()), 32'd0);

        // Branch in the same cycle as a response.
        exp_addr_q = '{32'h1008, 32'h100C, 32'h3000, 32'h3004};
        exp_data_q = '{32'h5A5A_3000, 32'h5A5A_3004};
        tick(1); pop_req = 2;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (req && addr == 32'h100C) found = 1'b1;
        end
        check1("s5 req 100c", found, 1'b1);
        branch = 1'b1; branch_addr = 32'h3000;
        #3;
        check1("s5 rvalid", rvalid, 1'b1);
        check1("s5 no push", push, 1'b0);
        check1("s5 flush", flush, 1'b1);
        tick(1); branch = 1'b0;
        #3;
        check32("s5 discard", 32'(dut.discard_q), 32'd1);
        tick(10); #3;
        check32("s5 addr left", 32'(exp_addr_q.size()), 32'd0);
        check32("s5 data left", 32'(exp_data_q.size()), 32'd0);

        // Random grants, responses, pops and branches against the stream model.
        tick(1);
        stream_addr = 32'h3008; stream_pushes = 0; stream_mode = 1'b1;
        gnt_mode = 2; rsp_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            int r;
            fetch_en = ($urandom_range(0, 7) != 0);
            branch = 1'b0;
            r = $urandom_range(0, 24);
            if (r == 0) begin
                branch = 1'b1; branch_addr = $urandom & 32'h0000_FFFF;
            end else if (r == 1) begin
                branch = 1'b1; branch_addr = 32'hFFFF_FFF0 | ($urandom & 32'h3);
            end
            pop_req = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
            tick(1);
        end
        branch = 1'b0; fetch_en = 1'b0; gnt_mode = 0; rsp_mode = 0; pop_req = 2;
        for (int i = 0; i < 50 && busy; i++) begin
            tick(1);
            pop_req = 2;
        end
        #3;
        check1("drain busy", busy, 1'b0);
        check1("stream pushes seen", stream_pushes != 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
